// File: rtl/meta_decode_mp.sv
// meta_decode_mp: typed DMA metadata cache with NUM_RD_PORTS 1-cycle scheduler read ports.
// Define META_DECODE_CHKSUM_EN to add the running rotate-xor load checksum (flag[3]).
module meta_decode_mp #(
    parameter int DATA_W       = 32,
    parameter int DEPTH        = 256,
    parameter int NUM_RD_PORTS = 2,
    parameter int REG_DEPTH    = DEPTH / 4,
    parameter int IDX_W        = $clog2(REG_DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_W-1:0]              dma_meta_data,
    input  logic [1:0]                     dma_meta_type,
    input  logic                           dma_meta_valid,
    input  logic                           dma_meta_last,
    output logic                           dma_meta_ready,
    input  logic [NUM_RD_PORTS-1:0]        sched_ren,
    input  logic [2*NUM_RD_PORTS-1:0]      sched_rtype,
    input  logic [IDX_W*NUM_RD_PORTS-1:0]  sched_ridx,
    output logic [DATA_W*NUM_RD_PORTS-1:0] sched_rdata,
    output logic [NUM_RD_PORTS-1:0]        sched_rvalid,
    output logic [NUM_RD_PORTS-1:0]        sched_rmiss,
    input  logic [15:0]                    cfg_expected_words,
    input  logic [31:0]                    cfg_expected_chk,
    input  logic                           ctrl_clear,
    output logic                           load_done,
    output logic [31:0]                    perf_hits,
    output logic [31:0]                    perf_misses,
    output logic [31:0]                    perf_load_cycles,
    output logic                           meta_error,
    output logic [3:0]                     meta_error_flags
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [1:0] ERR  = 2'd3;
    localparam int PC_W = $clog2(NUM_RD_PORTS + 1);
    localparam logic [IDX_W:0] FULL = (IDX_W + 1)'(REG_DEPTH);

    logic [1:0]              state, state_nxt;
    logic [DATA_W-1:0]       mem [DEPTH];
    // fill[3] is never written, so type-3 reads always miss
    logic [IDX_W:0]          fill [4];
    logic [15:0]             cnt;
    logic [3:0]              flags, flags_set;
    logic                    acc, bad, ovf, wr, fin, cnt_err, chk_err, load_tick;
    logic [NUM_RD_PORTS-1:0] hit, miss;
    logic [PC_W-1:0]         n_hit, n_miss;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [PC_W-1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

`ifdef META_DECODE_CHKSUM_EN
    logic [31:0] chk, chk_nxt;
    assign chk_nxt = {chk[30:0], chk[31]} ^ dma_meta_data[31:0];
    assign chk_err = fin && chk_nxt != cfg_expected_chk;
    always_ff @(posedge clk)
        if (rst || ctrl_clear) chk <= '0;
        else if (wr) chk <= chk_nxt;
`else
    logic unused_chk;
    assign unused_chk = ^cfg_expected_chk;
    assign chk_err = 1'b0;
`endif

    assign dma_meta_ready   = state == IDLE || state == LOAD;
    assign load_done        = state == DONE;
    assign meta_error_flags = flags;
    assign meta_error       = |flags;

    always_comb begin
        acc       = dma_meta_valid && dma_meta_ready && !ctrl_clear;
        bad       = acc && dma_meta_type == 2'd3;
        ovf       = acc && !bad && fill[dma_meta_type] == FULL;
        wr        = acc && !bad && !ovf;
        fin       = wr && dma_meta_last;
        cnt_err   = fin && cnt + 16'd1 != cfg_expected_words;
        flags_set = {chk_err, cnt_err, ovf, bad};
        load_tick = state == LOAD || (state == IDLE && acc);
        state_nxt = ctrl_clear ? IDLE :
                    (bad || ovf || cnt_err || chk_err) ? ERR :
                    fin ? DONE :
                    (wr && state == IDLE) ? LOAD : state;
    end

    // hit test uses the fill seen at the sampling edge, so a word written this cycle reads as a miss
    always_comb begin
        hit    = '0;
        miss   = '0;
        n_hit  = '0;
        n_miss = '0;
        for (int p = 0; p < NUM_RD_PORTS; p++) begin
            hit[p]  = sched_ren[p] && {1'b0, sched_ridx[p*IDX_W +: IDX_W]} < fill[sched_rtype[2*p +: 2]];
            miss[p] = sched_ren[p] && !hit[p];
            n_hit   = n_hit + PC_W'(hit[p]);
            n_miss  = n_miss + PC_W'(miss[p]);
        end
    end

    always_ff @(posedge clk)
        if (wr) mem[{dma_meta_type, fill[dma_meta_type][IDX_W-1:0]}] <= dma_meta_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            flags            <= '0;
            perf_hits        <= '0;
            perf_misses      <= '0;
            perf_load_cycles <= '0;
            for (int t = 0; t < 4; t++) fill[t] <= '0;
        end else begin
            state            <= state_nxt;
            perf_hits        <= sat_add(perf_hits, n_hit);
            perf_misses      <= sat_add(perf_misses, n_miss);
            perf_load_cycles <= sat_add(perf_load_cycles, PC_W'(load_tick));
            if (ctrl_clear) begin
                cnt   <= '0;
                flags <= '0;
                for (int t = 0; t < 4; t++) fill[t] <= '0;
            end else begin
                flags <= flags | flags_set;
                if (wr) begin
                    cnt                 <= cnt + 16'd1;
                    fill[dma_meta_type] <= fill[dma_meta_type] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sched_rvalid <= '0;
            sched_rmiss  <= '0;
            sched_rdata  <= '0;
        end else begin
            sched_rvalid <= sched_ren;
            sched_rmiss  <= miss;
            for (int p = 0; p < NUM_RD_PORTS; p++)
                sched_rdata[p*DATA_W +: DATA_W] <= hit[p] ?
                    mem[{sched_rtype[2*p +: 2], sched_ridx[p*IDX_W +: IDX_W]}] : '0;
        end
    end
endmodule

// File: tb/tb_meta_decode_mp.sv
// tb_meta_decode_mp: directed and random stimulus against a queue-based reference model;
// read responses go through per-port scoreboards popped by an independent monitor.
module tb_meta_decode_mp;
    localparam int DW = 32;
    localparam int NP = 2;
    localparam int RD = 64;
    localparam int IW = 6;

    typedef enum int {M_IDLE, M_LOAD, M_DONE, M_ERR} mst_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [DW-1:0]  dma_meta_data = '0;
    logic [1:0]     dma_meta_type = '0;
    logic           dma_meta_valid = 1'b0;
    logic           dma_meta_last = 1'b0;
    logic           dma_meta_ready;
    logic [NP-1:0]  sched_ren = '0;
    logic [2*NP-1:0] sched_rtype = '0;
    logic [IW*NP-1:0] sched_ridx = '0;
    logic [DW*NP-1:0] sched_rdata;
    logic [NP-1:0]  sched_rvalid, sched_rmiss;
    logic [15:0]    cfg_expected_words = '0;
    logic [31:0]    cfg_expected_chk = '0;
    logic           ctrl_clear = 1'b0;
    logic           load_done, meta_error;
    logic [31:0]    perf_hits, perf_misses, perf_load_cycles;
    logic [3:0]     meta_error_flags;

    always #5 clk = ~clk;

    meta_decode_mp dut (
        .clk(clk), .rst(rst),
        .dma_meta_data(dma_meta_data), .dma_meta_type(dma_meta_type),
        .dma_meta_valid(dma_meta_valid), .dma_meta_last(dma_meta_last),
        .dma_meta_ready(dma_meta_ready),
        .sched_ren(sched_ren), .sched_rtype(sched_rtype), .sched_ridx(sched_ridx),
        .sched_rdata(sched_rdata), .sched_rvalid(sched_rvalid), .sched_rmiss(sched_rmiss),
        .cfg_expected_words(cfg_expected_words), .cfg_expected_chk(cfg_expected_chk),
        .ctrl_clear(ctrl_clear), .load_done(load_done),
        .perf_hits(perf_hits), .perf_misses(perf_misses), .perf_load_cycles(perf_load_cycles),
        .meta_error(meta_error), .meta_error_flags(meta_error_flags)
    );

    int errs = 0;
    int checks = 0;

    mst_t        m_state;
    logic [3:0]  m_flags;
    int          m_cnt;
    logic [31:0] m_chk, m_hits, m_miss, m_lc;
    logic [31:0] mq [3][$];
    logic [32:0] sb [NP][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rot_x(input logic [31:0] c, input logic [31:0] d);
        return {c[30:0], c[31]} ^ d;
    endfunction

    function automatic logic [31:0] sat1(input logic [31:0] a);
        return a == 32'hFFFF_FFFF ? a : a + 1;
    endfunction

    task automatic model_clear();
        m_state = M_IDLE;
        m_flags = '0;
        m_cnt   = 0;
        m_chk   = '0;
        for (int t = 0; t < 3; t++) mq[t].delete();
    endtask

    task automatic check_status();
        check("ready", dma_meta_ready, (m_state == M_IDLE || m_state == M_LOAD));
        check("load_done", load_done, m_state == M_DONE);
        check("flags", meta_error_flags, m_flags);
        check("meta_error", meta_error, |m_flags);
        check("perf_hits", perf_hits, m_hits);
        check("perf_misses", perf_misses, m_miss);
        check("perf_load_cycles", perf_load_cycles, m_lc);
    endtask

    // Predicts the effect of the inputs currently driven, then advances one clock.
    task automatic tick();
        logic [1:0] rt;
        logic [IW-1:0] ri;
        logic hit;
        int ty;
        bit e;
        for (int p = 0; p < NP; p++) begin
            if (sched_ren[p]) begin
                rt = sched_rtype[2*p +: 2];
                ri = sched_ridx[p*IW +: IW];
                hit = 1'b0;
                if (rt != 2'd3) if (int'(ri) < mq[rt].size()) hit = 1'b1;
                if (hit) begin
                    sb[p].push_back({1'b0, mq[rt][ri]});
                    m_hits = sat1(m_hits);
                end else begin
                    sb[p].push_back({1'b1, 32'h0});
                    m_miss = sat1(m_miss);
                end
            end
        end
        if (m_state == M_LOAD || (m_state == M_IDLE && dma_meta_valid && !ctrl_clear)) m_lc = sat1(m_lc);
        ty = int'(dma_meta_type);
        if (ctrl_clear) model_clear();
        else if (dma_meta_valid && (m_state == M_IDLE || m_state == M_LOAD)) begin
            if (ty == 3) begin
                m_flags[0] = 1'b1;
                m_state = M_ERR;
            end else if (mq[ty].size() == RD) begin
                m_flags[1] = 1'b1;
                m_state = M_ERR;
            end else begin
                mq[ty].push_back(dma_meta_data);
                m_cnt++;
                m_chk = rot_x(m_chk, dma_meta_data);
                if (dma_meta_last) begin
                    e = 1'b0;
                    if (m_cnt != int'(cfg_expected_words)) begin m_flags[2] = 1'b1; e = 1'b1; end
`ifdef META_DECODE_CHKSUM_EN
                    if (m_chk != cfg_expected_chk) begin m_flags[3] = 1'b1; e = 1'b1; end
`endif
                    m_state = e ? M_ERR : M_DONE;
                end else if (m_state == M_IDLE) m_state = M_LOAD;
            end
        end
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        dma_meta_valid = 1'b0;
        dma_meta_last = 1'b0;
        sched_ren = '0;
        ctrl_clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        m_hits = '0;
        m_miss = '0;
        m_lc = '0;
        check_status();
    endtask

    task automatic send(input logic [1:0] ty, input logic [31:0] d, input logic last);
        dma_meta_valid = 1'b1;
        dma_meta_type = ty;
        dma_meta_data = d;
        dma_meta_last = last;
        tick();
        dma_meta_valid = 1'b0;
        dma_meta_last = 1'b0;
    endtask

    task automatic rd1(input logic [1:0] ty, input logic [IW-1:0] idx);
        sched_ren = 2'b01;
        sched_rtype = {2'd0, ty};
        sched_ridx = {6'd0, idx};
        tick();
        sched_ren = '0;
    endtask

    task automatic clear();
        ctrl_clear = 1'b1;
        tick();
        ctrl_clear = 1'b0;
    endtask

    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (sched_rvalid[p]) begin
                    if (sb[p].size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_rvalid port %0d: got rvalid=1 expected 0 at %0t", p, $time);
                    end else begin
                        e = sb[p].pop_front();
                        check($sformatf("rdata_p%0d", p), sched_rdata[p*DW +: DW], e[31:0]);
                        check($sformatf("rmiss_p%0d", p), sched_rmiss[p], e[32]);
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] c;
        int plan;
        do_reset();
        check("rst_ready", dma_meta_ready, 1);
        check("rst_flags", meta_error_flags, 0);

        cfg_expected_words = 16'd10;
        c = '0;
        for (int i = 0; i < 10; i++) c = rot_x(c, 32'h1000_0000 + 32'(16 * i));
        cfg_expected_chk = c;
        for (int i = 0; i < 10; i++) send(2'd0, 32'h1000_0000 + 32'(16 * i), i == 9);
        check("t1_done", load_done, 1);
        check("t1_ready", dma_meta_ready, 0);
        check("t1_load_cycles", perf_load_cycles, 10);
        rd1(2'd0, 6'd3);
        check("t1_rdata", sched_rdata[31:0], 32'h1000_0030);
        check("t1_rvalid", sched_rvalid[0], 1);
        check("t1_rmiss", sched_rmiss[0], 0);

        sched_ren = 2'b11;
        sched_rtype = {2'd1, 2'd0};
        sched_ridx = {6'd0, 6'd9};
        tick();
        sched_ren = '0;
        check("t2_p0_data", sched_rdata[31:0], 32'h1000_0090);
        check("t2_p0_miss", sched_rmiss[0], 0);
        check("t2_p1_miss", sched_rmiss[1], 1);
        check("t2_p1_data", sched_rdata[63:32], 0);
        check("t2_hits", perf_hits, 2);
        check("t2_misses", perf_misses, 1);

        clear();
        check("t3_clr_ready", dma_meta_ready, 1);
        cfg_expected_words = 16'd100;
        for (int i = 0; i < 3; i++) send(2'd0, 32'hA000_0000 + 32'(i), 1'b0);
        send(2'd3, 32'hDEAD_BEEF, 1'b0);
        check("t3_err", meta_error, 1);
        check("t3_flags", meta_error_flags, 4'h1);
        check("t3_ready", dma_meta_ready, 0);
        rd1(2'd0, 6'd3);
        check("t3_dropped", sched_rmiss[0], 1);
        clear();
        check("t3_cleared", meta_error_flags, 0);
        check("t3_ready2", dma_meta_ready, 1);

        for (int i = 0; i < 65; i++) send(2'd1, 32'h2000_0000 + 32'(i), 1'b0);
        check("t4_ovf", meta_error_flags, 4'h2);
        rd1(2'd1, 6'd63);
        check("t4_rd63", sched_rdata[31:0], 32'h2000_003F);
        check("t4_rd63_miss", sched_rmiss[0], 0);
        clear();

        cfg_expected_words = 16'd6;
        c = '0;
        for (int i = 0; i < 5; i++) c = rot_x(c, 32'h3000_0000 + 32'(i));
        cfg_expected_chk = c;
        for (int i = 0; i < 5; i++) send(2'd2, 32'h3000_0000 + 32'(i), i == 4);
        check("t5_flags", meta_error_flags, 4'h4);
        check("t5_done", load_done, 0);
        clear();

        cfg_expected_words = 16'd2;
        cfg_expected_chk = 32'h4;
        send(2'd0, 32'h1, 1'b0);
        send(2'd0, 32'h2, 1'b1);
`ifdef META_DECODE_CHKSUM_EN
        check("t6_flags", meta_error_flags, 4'h8);
        check("t6_done", load_done, 0);
`else
        check("t6_flags", meta_error_flags, 4'h0);
        check("t6_done", load_done, 1);
`endif
        clear();
        cfg_expected_chk = 32'h0;
        send(2'd0, 32'h1, 1'b0);
        send(2'd0, 32'h2, 1'b1);
        check("t6_match_done", load_done, 1);
        check("t6_match_flags", meta_error_flags, 0);
        clear();

        cfg_expected_words = 16'd20;
        for (int i = 0; i < 4; i++) send(2'd0, 32'h4000_0000 + 32'(i), 1'b0);
        do_reset();
        check("t7_ready", dma_meta_ready, 1);
        check("t7_hits", perf_hits, 0);
        check("t7_lc", perf_load_cycles, 0);
        rd1(2'd0, 6'd0);
        check("t7_miss", sched_rmiss[0], 1);

        plan = 1;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
                continue;
            end
            if (m_state == M_IDLE) begin
                plan = $urandom_range(1, 12);
                cfg_expected_words = 16'(($urandom_range(0, 3) == 0) ? plan + 1 : plan);
            end
            ctrl_clear = (m_state == M_DONE || m_state == M_ERR) ? ($urandom_range(0, 3) == 0)
                                                                 : ($urandom_range(0, 149) == 0);
            dma_meta_valid = $urandom_range(0, 2) != 0;
            dma_meta_type = ($urandom_range(0, 40) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            dma_meta_data = $urandom;
            dma_meta_last = m_cnt + 1 >= plan;
            cfg_expected_chk = ($urandom_range(0, 3) == 0) ? $urandom : rot_x(m_chk, dma_meta_data);
            for (int p = 0; p < NP; p++) begin
                sched_ren[p] = 1'($urandom_range(0, 1));
                sched_rtype[2*p +: 2] = 2'($urandom_range(0, 3));
                sched_ridx[p*IW +: IW] = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63))
                                                                     : 6'($urandom_range(0, 13));
            end
            tick();
        end
        dma_meta_valid = 1'b0;
        ctrl_clear = 1'b0;
        sched_ren = '0;
        tick();
        tick();
        for (int p = 0; p < NP; p++) check($sformatf("sb_empty_p%0d", p), sb[p].size(), 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
